instruction_fetch_unit: RTL and testbench

//  Fetch stage ahead of decode/control. Holds the PC and runs a req/ack handshake with instruction memory.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/pc_reg.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               fetch_state_t  - fetch FSM state encoding (IDLE/REQ/HOLD)
//               NOP_INST       - instruction presented to decode after reset
//               PC_STEP        - sequential PC increment in bytes
//               RESET_PC_DEF   - default first fetch address
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam int          PC_STEP      = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter register with load enable.
//   clk     in   1     clock, rising edge
//   rst_n   in   1     synchronous active-low reset, loads RESET_PC
//   i_load  in   1     load enable
//   i_d     in   XLEN  next PC value
//   o_q     out  XLEN  current PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_d,
   output logic [XLEN-1:0] o_q
);

   logic [XLEN-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= i_d;
      end
   end

   assign o_q = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage. Holds the PC, runs a req/ack handshake with
//               instruction memory and hands one instruction at a time to
//               decode over a valid/ready handshake. Not pipelined: one
//               request is outstanding at most, and a new one is issued only
//               after the held instruction is consumed or flushed.
//   clk            in   1     clock, rising edge
//   rst_n          in   1     synchronous active-low reset
//   imem_req       out  1     fetch request
//   imem_addr      out  XLEN  word-aligned fetch address
//   imem_ack       in   1     response valid, imem_rdata valid this cycle
//   imem_rdata     in   32    fetched instruction word
//   redirect_valid in   1     branch taken, restart fetch at redirect_pc
//   redirect_pc    in   XLEN  branch target (bits [1:0] ignored)
//   inst_valid     out  1     inst_out/pc_out deliverable
//   id_ready       in   1     decode accepts this cycle
//   inst_out       out  32    instruction to decode
//   pc_out         out  XLEN  address of inst_out
//   fetch_count    out  32    number of delivered instructions (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            id_ready,
   output logic [31:0]     inst_out,
   output logic [XLEN-1:0] pc_out,
   output logic [31:0]     fetch_count
);

   localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_pc_load;
   logic [XLEN-1:0] w_redir_pc;
   logic            w_fire;
   logic            w_capture;
   logic [31:0]     r_inst_q;
   logic [XLEN-1:0] r_pc_q;
   logic            r_squash;
   logic [XLEN-1:0] r_pend_pc;
   logic [31:0]     r_fetch_count;

   assign w_redir_pc = redirect_pc & c_align_mask;

   pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_pc_load),
      .i_d    (w_pc_nxt),
      .o_q    (w_pc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pc_load   = 1'b0;
      w_pc_nxt    = w_pc;
      w_fire      = 1'b0;
      w_capture   = 1'b0;
      imem_req    = 1'b0;
      inst_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt = REQ;
            if (redirect_valid) begin
               w_pc_load = 1'b1;
               w_pc_nxt  = w_redir_pc;
            end
         end
         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (r_squash || redirect_valid) begin
                  // Response belongs to a stale path: drop it and re-request
                  // from the newest target, preferring a same-cycle redirect.
                  w_pc_load = 1'b1;
                  w_pc_nxt  = redirect_valid ? w_redir_pc : r_pend_pc;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            // A redirect flushes the held instruction in the same cycle, so
            // decode must never see it as valid.
            inst_valid = !redirect_valid;
            w_fire     = inst_valid && id_ready;
            if (redirect_valid) begin
               w_pc_load   = 1'b1;
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = REQ;
            end else if (id_ready) begin
               w_pc_load   = 1'b1;
               w_pc_nxt    = r_pc_q + XLEN'(PC_STEP);
               w_state_nxt = REQ;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_squash      <= 1'b0;
         r_pend_pc     <= RESET_PC;
         r_inst_q      <= NOP_INST;
         r_pc_q        <= '0;
         r_fetch_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == REQ) begin
            if (imem_ack) begin
               r_squash <= 1'b0;
            end else if (redirect_valid) begin
               // Address must stay stable mid-request; remember the target.
               r_squash  <= 1'b1;
               r_pend_pc <= w_redir_pc;
            end
         end
         if (w_capture) begin
            r_inst_q <= imem_rdata;
            r_pc_q   <= w_pc;
         end
         if (w_fire) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   assign imem_addr   = w_pc;
   assign inst_out    = r_inst_q;
   assign pc_out      = r_pc_q;
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A memory
//               model with random ack latency and a transaction-level
//               reference of the fetch rules predict every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        id_ready;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .id_ready       (id_ready),
      .inst_out       (inst_out),
      .pc_out         (pc_out),
      .fetch_count    (fetch_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: what the fetch stage is doing, in transaction terms.
   // m_phase 0 = waiting one cycle after reset, 1 = request outstanding,
   // 2 = instruction parked for decode.
   int          m_phase;
   logic [31:0] m_pc, m_inst, m_ipc, m_pend, m_cnt;
   bit          m_stale;
   int          m_wait, m_delay;
   int          dmin, dmax;

   function automatic logic [31:0] align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   task automatic new_req();
      m_phase = 1;
      m_wait  = 0;
      m_delay = $urandom_range(dmax, dmin);
   endtask

   task automatic m_reset();
      m_phase = 0;
      m_pc    = RST_PC;
      m_inst  = 32'h0000_0013;
      m_ipc   = 32'h0;
      m_pend  = RST_PC;
      m_cnt   = 32'h0;
      m_stale = 1'b0;
      m_wait  = 0;
      m_delay = 0;
   endtask

   // One clock: apply inputs, check outputs mid-cycle, advance the model.
   task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc,
                        input bit rdy, input bit spur);
      bit          ack;
      logic [31:0] rd;
      ack = (m_phase == 1 && m_wait >= m_delay) || (spur && m_phase == 0);
      rd  = $urandom;
      rst_n          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      imem_ack       = ack;
      imem_rdata     = rd;
      @(negedge clk);
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_phase == 1});
      if (m_phase == 1) chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_phase == 2 && !rv});
      chk("inst_out", inst_out, m_inst);
      chk("pc_out", pc_out, m_ipc);
      chk("fetch_count", fetch_count, m_cnt);
      if (!rst) begin
         m_reset();
      end else begin
         case (m_phase)
            0: begin
               if (rv) m_pc = align(rpc);
               new_req();
            end
            1: begin
               if (ack) begin
                  if (m_stale || rv) begin
                     m_pc    = rv ? align(rpc) : m_pend;
                     m_stale = 1'b0;
                     new_req();
                  end else begin
                     m_inst  = rd;
                     m_ipc   = m_pc;
                     m_phase = 2;
                  end
               end else begin
                  m_wait++;
                  if (rv) begin
                     m_stale = 1'b1;
                     m_pend  = align(rpc);
                  end
               end
            end
            default: begin
               if (rv) begin
                  m_pc = align(rpc);
                  new_req();
               end else if (rdy) begin
                  m_pc  = m_ipc + 32'd4;
                  m_cnt = m_cnt + 32'd1;
                  new_req();
               end
            end
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_phase(input int p, input bit rdy);
      int n;
      n = 0;
      while (m_phase != p && n < 50) begin
         cycle(1'b1, 1'b0, 32'h0, rdy, 1'b0);
         n++;
      end
      chk("phase_reached", {31'b0, m_phase == p}, 32'h1);
   endtask

   initial begin
      bit          rv, rdy, rst, spur;
      logic [31:0] rpc;
      int          n;
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      dmin = 1; dmax = 1;
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Sequential fetch, ack one cycle after each request, decode always ready.
      n = 0;
      while (m_cnt != 32'd4 && n < 40) begin
         cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
         n++;
      end
      chk("four_fires", fetch_count, 32'd4);

      // Decode stalls for 5 cycles while an instruction is parked.
      run_until_phase(2, 1'b0);
      repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

      // Redirect while a slow request is outstanding.
      dmin = 3; dmax = 3;
      run_until_phase(1, 1'b1);
      cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
      repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

      // Redirect in HOLD with decode ready the same cycle.
      dmin = 0; dmax = 1;
      run_until_phase(2, 1'b0);
      cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
      repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

      // Misaligned target, then PC wrap at the top of the address space.
      run_until_phase(2, 1'b0);
      cycle(1'b1, 1'b1, 32'h0000_0206, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      run_until_phase(2, 1'b0);
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

      // Reset mid-request with late acks arriving during reset and IDLE.
      dmin = 3; dmax = 3;
      run_until_phase(1, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

      // Randomized traffic.
      dmin = 0; dmax = 3;
      for (int i = 0; i < 3000; i++) begin
         rv   = ($urandom_range(0, 9) == 0);
         rdy  = ($urandom_range(0, 3) != 0);
         rst  = ($urandom_range(0, 199) != 0);
         spur = $urandom_range(0, 1) != 0;
         case ($urandom_range(0, 4))
            0:       rpc = 32'h0000_0100;
            1:       rpc = 32'h0000_0206;
            2:       rpc = 32'hFFFF_FFFC;
            3:       rpc = $urandom;
            default: rpc = 32'h0000_0200;
         endcase
         cycle(rst, rv, rpc, rdy, spur);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
